// File: rtl/dmem_arbiter.sv
// Data-RAM port arbiter between Memory stage M1 (port 0) and the loader/debug master (port 1).
// Port 0 has default priority, port 1 is promoted after MAX_WAIT refusals, and port 1 may lock bounded bursts.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    P0_PRI  = 2'd0,
    P1_PRI  = 2'd1,
    P1_LOCK = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  // A one-grant burst limit means the entering grant already exhausts the burst.
  localparam logic       LOCK_OK   = (MAX_BURST > 1);

  state_t            state, state_next;
  logic [3:0]        wait_cnt, wait_next;
  logic [3:0]        burst_cnt, burst_next;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata_q;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_next = state;
    wait_next  = wait_cnt;
    burst_next = burst_cnt;

    case (state)
      P0_PRI: begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
      end
      P1_PRI: begin
        gnt1 = req1;
        gnt0 = req0 & ~req1;
      end
      P1_LOCK: begin
        gnt1 = req1;
      end
      default: ;
    endcase

    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt1) begin
      wait_next = 4'd0;
    end else if (req1 && (wait_cnt < WAIT_MAX)) begin
      wait_next = wait_cnt + 4'd1;
    end

    case (state)
      P0_PRI, P1_PRI: begin
        if (gnt1) begin
          if (lock1 && LOCK_OK) begin
            state_next = P1_LOCK;
            burst_next = 4'd1;
          end else begin
            state_next = P0_PRI;
          end
        end else if ((state == P0_PRI) && (wait_next == WAIT_MAX)) begin
          state_next = P1_PRI;
        end
      end
      P1_LOCK: begin
        // Port 1 owns the RAM here, so it never accumulates wait credit.
        wait_next = 4'd0;
        if (gnt1) begin
          burst_next = burst_cnt + 4'd1;
        end
        if (!req1 || !lock1 || (burst_next >= BURST_MAX)) begin
          state_next = P0_PRI;
          burst_next = 4'd0;
        end
      end
      default: begin
        state_next = P0_PRI;
        burst_next = 4'd0;
      end
    endcase
  end

  always_comb begin
    ram_en    = gnt0 | gnt1;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt1) begin
      ram_we    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end else if (gnt0) begin
      ram_we    = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= P0_PRI;
      wait_cnt  <= 4'd0;
      burst_cnt <= 4'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_next;
      burst_cnt <= burst_next;
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (rvalid0_q || rvalid1_q) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  // The read tag doubles as rvalid; outputs are masked while reset is held so a read
  // granted just before reset never surfaces.
  assign rvalid0 = rvalid0_q & ~reset;
  assign rvalid1 = rvalid1_q & ~reset;
  assign rdata   = reset ? '0 : ((rvalid0_q || rvalid1_q) ? ram_rdata : rdata_q);

  a_one_grant : assert property (@(posedge clock) !(gnt0 && gnt1));
  a_lock_excl : assert property (@(posedge clock) (state == P1_LOCK) |-> !gnt0);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-RAM port between the Memory pipeline stage (port 0, load/store traffic) and the RAM loader/debug master (port 1, initialization and inspection bursts). Port 0 has priority by default. A wait counter guarantees port 1 forward progress, and a lock input lets port 1 run bounded bursts. The block sits between Memory stage M1 and the data RAM and drives the RAM port directly.

## Interface
- ADDR_W, 32, byte-address width passed through to RAM
- DATA_W, 32, data width
- MAX_WAIT, 4, cycles port 1 may be refused before it is promoted (1..15)
- MAX_BURST, 8, maximum grants in one port-1 locked burst (1..15)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- lock1  in  1  port 1 requests burst ownership
- gnt0 / gnt1  out  1  access accepted this cycle
- rvalid0 / rvalid1  out  1  read data valid on rdata, one cycle after a read grant
- rdata  out  DATA_W  read data, shared by both ports
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0

## Operation
- Handshake: the requester holds req, we, addr and wdata stable until it sees gnt high in the same cycle. gnt is combinational from the req inputs and the registered state.
- At most one grant per cycle.
- ram_en = gnt0 | gnt1. ram_we, ram_addr and ram_wdata are muxed from the granted port. When neither port is granted, ram_we = 0 and addr/wdata are don't-care.
- Read tag register: on a read grant, store the port id. Next cycle, raise rvalidN for that port and drive rdata = ram_rdata. Writes produce no rvalid. rdata holds its last value when no rvalid is asserted.
- wait_cnt (4 bits):
  - increments each cycle req1=1 and gnt1=0, saturating at MAX_WAIT;
  - clears on gnt1.
- FSM states:
  - P0_PRI (reset state): grant port 0 if req0, else port 1 if req1. Go to P1_PRI when wait_cnt reaches MAX_WAIT. Go to P1_LOCK on a gnt1 with lock1=1.
  - P1_PRI: grant port 1 if req1, else port 0 if req0. After a gnt1, go to P1_LOCK if lock1=1, otherwise to P0_PRI.
  - P1_LOCK: only port 1 may be granted; gnt0 = 0 even when req0 is high. burst_cnt counts grants, and the entering grant counts as 1. Return to P0_PRI and clear burst_cnt when any of these holds:
    - req1=0;
    - lock1=0;
    - burst_cnt reaches MAX_BURST after a grant.
- On exit from P1_LOCK, wait_cnt is 0. If req0 is pending, port 0 wins the next cycle.
- Simultaneous req0 and req1 in P0_PRI with wait_cnt < MAX_WAIT: port 0 wins, and wait_cnt increments.

## Timing
- Grant latency: 0 cycles (same-cycle gnt).
- Read data latency: rvalid/rdata 1 cycle after the grant.
- Pipelining: back-to-back grants on consecutive cycles are allowed, giving a sustained rate of 1 access/cycle.
- Port 1 worst-case wait under continuous req0: MAX_WAIT cycles. It is granted in cycle MAX_WAIT+1 after it first asserts req1.
- Reset (synchronous; takes effect at the clock edge where reset=1):
  - state = P0_PRI;
  - wait_cnt, burst_cnt = 0;
  - read tag invalid;
  - registered outputs rvalid0/1 = 0, rdata = 0.
- While reset=1, gnt0/1, ram_en and ram_we are forced to 0.
- Reset mid-read: the pending read is dropped, and no rvalid is asserted on the cycle after reset deasserts.

## Test plan
- Single read on port 0 at addr 0x10 with RAM word 0xDEADBEEF: gnt0 the same cycle, then rvalid0=1 and rdata=0xDEADBEEF the next cycle; rvalid1 stays 0.
- req0 and req1 held high continuously (MAX_WAIT=4): gnt0 in cycles 1-4, gnt1 in cycle 5, then gnt0 resumes; wait_cnt returns to 0.
- Port 1 locked write burst of 10 words with MAX_BURST=8 and req0 high throughout: 8 consecutive gnt1, then one gnt0, then port 1 resumes under the wait rule; ram_we=1 on each gnt1.
- Port 1 deasserts lock1 after 3 grants while req0 is high: FSM returns to P0_PRI and gnt0 is asserted on the next cycle.
- Interleaved read0, write1, read1 on consecutive cycles: rvalid0 and rvalid1 each fire exactly one cycle after their own read grant, with the correct RAM data; no rvalid follows the write.
- reset asserted for one cycle, in the cycle after a port-0 read grant: no rvalid0 afterwards, all outputs 0 during reset, FSM in P0_PRI with counters at 0.
